// File: rtl/spi_sprite_loader_if.sv
// -----------------------------------------------------------------------------
// spi_sprite_loader_if
// Groups the four external SPI pins of the sprite loader.
//   spi_sclk  SPI clock (mode 0), asynchronous to the pixel clock
//   spi_mosi  serial data from the master, MSB first
//   spi_cs    chip select, active low
//   spi_miso  serial data to the master
// Modports: master drives sclk/mosi/cs and reads miso; slave is the reverse.
// -----------------------------------------------------------------------------
interface spi_sprite_loader_if;
   logic spi_sclk;
   logic spi_mosi;
   logic spi_cs;
   logic spi_miso;

   modport master (output spi_sclk, output spi_mosi, output spi_cs, input spi_miso);
   modport slave  (input spi_sclk, input spi_mosi, input spi_cs, output spi_miso);
endinterface

// File: rtl/spi_sprite_loader.sv
// -----------------------------------------------------------------------------
// spi_sprite_loader
// SPI slave plus double-buffered register file for the sprite renderer.
// Command/payload bytes arriving over SPI update a shadow register set
// (background colour, sprite colour, 1 bpp bitmap, X/Y position). The shadow
// set is copied to the outputs on a next_frame pulse while chip select is
// high, so the renderer never sees a half-written sprite.
//
// Parameters:
//   SPRITE_BYTES  bitmap length in bytes (18 = 12x12 pixels)
//   POS_W         width of the sprite coordinates
// Ports:
//   clk           pixel clock
//   reset_n       asynchronous active-low reset
//   spi           SPI pins (slave modport of spi_sprite_loader_if)
//   next_frame    one-cycle pulse at start of vertical blank
//   bg_color      committed background colour, rrggbb
//   sprite_color  committed sprite colour, rrggbb
//   sprite_data   committed bitmap, MSB = top-left pixel
//   sprite_x/y    committed sprite position
// Build option:
//   SPI_READBACK_EN  when defined, MISO echoes the previous received byte;
//                    otherwise MISO is tied low.
// Commands: 0x00 SET_COLOR (bg, sprite), 0x01 SET_SPRITE (bitmap bytes),
//           0x02 SET_POS (X hi/lo, Y hi/lo); anything else is ignored.
// -----------------------------------------------------------------------------
module spi_sprite_loader #(
   parameter int SPRITE_BYTES = 18,
   parameter int POS_W        = 10
) (
   input  logic                      clk,
   input  logic                      reset_n,
   spi_sprite_loader_if.slave        spi,
   input  logic                      next_frame,
   output logic [5:0]                bg_color,
   output logic [5:0]                sprite_color,
   output logic [8*SPRITE_BYTES-1:0] sprite_data,
   output logic [POS_W-1:0]          sprite_x,
   output logic [POS_W-1:0]          sprite_y
);

   localparam int BMP_W = 8 * SPRITE_BYTES;

   localparam logic [7:0] CMD_SET_COLOR  = 8'h00;
   localparam logic [7:0] CMD_SET_SPRITE = 8'h01;
   localparam logic [7:0] CMD_SET_POS    = 8'h02;

   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_e;

   state_e           state_q, state_d;

   logic [2:0]       sclk_sync_q;
   logic [2:0]       cs_sync_q;
   logic [1:0]       mosi_sync_q;

   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       byte_idx_q, byte_idx_d;
   logic [7:0]       rx_q, rx_d;
   logic [7:0]       cmd_q, cmd_d;

   // Shadow set written by SPI; positions kept as full 16-bit big-endian words.
   logic [5:0]       bg_sh_q, bg_sh_d;
   logic [5:0]       spr_col_sh_q, spr_col_sh_d;
   logic [BMP_W-1:0] bmp_sh_q, bmp_sh_d;
   logic [15:0]      x_sh_q, x_sh_d;
   logic [15:0]      y_sh_q, y_sh_d;

   // Committed set seen by the renderer.
   logic [5:0]       bg_q, bg_d;
   logic [5:0]       spr_col_q, spr_col_d;
   logic [BMP_W-1:0] bmp_q, bmp_d;
   logic [POS_W-1:0] x_q, x_d;
   logic [POS_W-1:0] y_q, y_d;

   logic             sclk_rise;
   logic             cs_fall;
   logic             cs_rise;
   logic             cs_low;
   logic             bit_tick;
   logic             byte_done;
   logic             commit;
   logic [7:0]       rx_byte;

   // ---------------------------------------------------------------------------
   // Input synchronizers. CS resets to "low" so that a reset taken in the
   // middle of a transaction does not fabricate a falling edge on release;
   // the slave stays idle until the master raises and lowers CS again.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
      end else begin
         // NOTE: sequential state uses <= so every flop samples the pre-edge
         // value; blocking here would collapse the synchronizer chain.
         sclk_sync_q <= {sclk_sync_q[1:0], spi.spi_sclk};
         cs_sync_q   <= {cs_sync_q[1:0], spi.spi_cs};
         mosi_sync_q <= {mosi_sync_q[0], spi.spi_mosi};
      end
   end

   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
   assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
   assign cs_low    = ~cs_sync_q[1];
   assign bit_tick  = sclk_rise & cs_low & (state_q != ST_IDLE);
   assign byte_done = bit_tick & (bit_cnt_q == 3'd7);
   assign rx_byte   = {rx_q[6:0], mosi_sync_q[1]};
   assign commit    = next_frame & ~cs_low;

   // ---------------------------------------------------------------------------
   // Transaction FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first; a path that
      // leaves a signal unassigned would otherwise infer a latch.
      state_d = state_q;
      if (cs_fall) begin
         state_d = ST_CMD;
      end else if (cs_rise) begin
         state_d = ST_IDLE;
      end else if (byte_done && state_q == ST_CMD) begin
         state_d = ST_DATA;
      end
   end

   // ---------------------------------------------------------------------------
   // Byte assembly, command decode and frame commit
   // ---------------------------------------------------------------------------
   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      byte_idx_d   = byte_idx_q;
      rx_d         = rx_q;
      cmd_d        = cmd_q;
      bg_sh_d      = bg_sh_q;
      spr_col_sh_d = spr_col_sh_q;
      bmp_sh_d     = bmp_sh_q;
      x_sh_d       = x_sh_q;
      y_sh_d       = y_sh_q;
      bg_d         = bg_q;
      spr_col_d    = spr_col_q;
      bmp_d        = bmp_q;
      x_d          = x_q;
      y_d          = y_q;

      if (cs_fall) begin
         bit_cnt_d  = '0;
         byte_idx_d = '0;
         rx_d       = '0;
      end else if (bit_tick) begin
         rx_d      = rx_byte;
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (byte_done) begin
            if (state_q == ST_CMD) begin
               cmd_d      = rx_byte;
               byte_idx_d = '0;
            end else begin
               if (byte_idx_q != 8'hFF) begin
                  byte_idx_d = byte_idx_q + 8'd1;
               end
               case (cmd_q)
                  CMD_SET_COLOR: begin
                     if (byte_idx_q == 8'd0) begin
                        bg_sh_d = rx_byte[5:0];
                     end else if (byte_idx_q == 8'd1) begin
                        spr_col_sh_d = rx_byte[5:0];
                     end
                  end
                  CMD_SET_SPRITE: begin
                     // Bytes scroll in from the LSB end, so after a full
                     // load the first byte sent sits in the MSBs.
                     if (int'(byte_idx_q) < SPRITE_BYTES) begin
                        bmp_sh_d = {bmp_sh_q[BMP_W-9:0], rx_byte};
                     end
                  end
                  CMD_SET_POS: begin
                     case (byte_idx_q)
                        8'd0:    x_sh_d[15:8] = rx_byte;
                        8'd1:    x_sh_d[7:0]  = rx_byte;
                        8'd2:    y_sh_d[15:8] = rx_byte;
                        8'd3:    y_sh_d[7:0]  = rx_byte;
                        default: ;
                     endcase
                  end
                  default: ;
               endcase
            end
         end
      end

      // Commit reads the registered shadow, so a byte completing in the same
      // cycle lands in the following frame.
      if (commit) begin
         bg_d      = bg_sh_q;
         spr_col_d = spr_col_sh_q;
         bmp_d     = bmp_sh_q;
         x_d       = POS_W'(x_sh_q);
         y_d       = POS_W'(y_sh_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt_q    <= '0;
         byte_idx_q   <= '0;
         rx_q         <= '0;
         cmd_q        <= '0;
         // NOTE: the bitmap is ordinary flops, not a RAM, and has a defined
         // power-up image, so it is reset along with everything else.
         bg_sh_q      <= 6'h00;
         spr_col_sh_q <= 6'h3F;
         bmp_sh_q     <= '0;
         x_sh_q       <= '0;
         y_sh_q       <= '0;
         bg_q         <= 6'h00;
         spr_col_q    <= 6'h3F;
         bmp_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
      end else begin
         bit_cnt_q    <= bit_cnt_d;
         byte_idx_q   <= byte_idx_d;
         rx_q         <= rx_d;
         cmd_q        <= cmd_d;
         bg_sh_q      <= bg_sh_d;
         spr_col_sh_q <= spr_col_sh_d;
         bmp_sh_q     <= bmp_sh_d;
         x_sh_q       <= x_sh_d;
         y_sh_q       <= y_sh_d;
         bg_q         <= bg_d;
         spr_col_q    <= spr_col_d;
         bmp_q        <= bmp_d;
         x_q          <= x_d;
         y_q          <= y_d;
      end
   end

   assign bg_color     = bg_q;
   assign sprite_color = spr_col_q;
   assign sprite_data  = bmp_q;
   assign sprite_x     = x_q;
   assign sprite_y     = y_q;

   // ---------------------------------------------------------------------------
   // Optional MISO readback: the byte just completed is reloaded on the first
   // falling edge of the next byte (bit counter wrapped to 0), so the master
   // reads byte n-1 while sending byte n. rx_q still holds that byte there,
   // because no further rising edge has arrived yet.
   // ---------------------------------------------------------------------------
`ifdef SPI_READBACK_EN
   logic [7:0] tx_q, tx_d;
   logic       sclk_fall;

   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];

   always_comb begin
      tx_d = tx_q;
      if (cs_fall) begin
         tx_d = '0;
      end else if (sclk_fall && cs_low && state_q != ST_IDLE) begin
         tx_d = (bit_cnt_q == 3'd0) ? rx_q : {tx_q[6:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_q <= '0;
      end else begin
         tx_q <= tx_d;
      end
   end

   assign spi.spi_miso = tx_q[7];
`else
   assign spi.spi_miso = 1'b0;
`endif

endmodule
